// File: rtl/oserdes_word_sched_if.sv
`default_nettype none
// ============================================================================
//  Module  : oserdes_word_sched_if
//  Purpose : Source handshakes and serializer word bus for oserdes_word_sched.
//  Revision: 1.0  initial release
// ============================================================================
interface oserdes_word_sched_if #(
   parameter int WORD_W = 10
);
   logic              a_valid;
   logic [WORD_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [WORD_W-1:0] b_data;
   logic              b_ready;
   logic              ser_load;
   logic [WORD_W-1:0] ser_word;

   // master: the scheduler; slave: sources and serializer
   modport master (
      input  a_valid, a_data, b_valid, b_data,
      output a_ready, b_ready, ser_load, ser_word
   );
   modport slave (
      output a_valid, a_data, b_valid, b_data,
      input  a_ready, b_ready, ser_load, ser_word
   );
endinterface
`default_nettype wire

// File: rtl/oserdes_word_sched.sv
`default_nettype none
// ============================================================================
//  Module  : oserdes_word_sched
//  Purpose : Word scheduler for a 10:1 DDR serializer lane: load strobe,
//            training bursts, A/B arbitration with idle fill.
//            Define OSCHED_PRBS_EN for PRBS7 training words.
//  Revision: 1.0  initial release
// ============================================================================
module oserdes_word_sched #(
   parameter int                WORD_W     = 10,
   parameter int                PHASES     = 5,
   parameter logic [WORD_W-1:0] TRAIN_WORD = 10'h3E0,
   parameter logic [WORD_W-1:0] IDLE_WORD  = 10'h155,
   parameter int                TRAIN_LEN  = 64,
   parameter int                STARV_MAX  = 4
) (
   input  logic                 clk_ser,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 train_req,
   oserdes_word_sched_if.master bus,
   output logic [2:0]           phase,
   output logic [1:0]           state_o,
   output logic                 train_done,
   output logic [15:0]          idle_cnt
);
   localparam int                 C_CNT_W      = $clog2(TRAIN_LEN + 1);
   localparam int                 C_STARV_W    = $clog2(STARV_MAX + 1);
   localparam logic [2:0]         C_LAST_PHASE = 3'(PHASES - 1);
   localparam logic [C_CNT_W-1:0] C_LAST_WORD  = C_CNT_W'(TRAIN_LEN - 1);
   localparam logic [C_CNT_W-1:0] C_FIRST_WORD = C_CNT_W'(1);
   localparam logic [C_STARV_W-1:0] C_STARV_LIM = C_STARV_W'(STARV_MAX);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_TRAIN = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           phase_q, phase_d;
   logic [WORD_W-1:0]    ser_word_q, ser_word_d;
   logic [C_CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [C_STARV_W-1:0] starv_q, starv_d;
   logic [15:0]          idle_cnt_q, idle_cnt_d;
   logic                 w_boundary;
   logic                 w_a_ready, w_b_ready, w_train_done;
   logic [WORD_W-1:0]    w_train_word;

   assign w_boundary = (phase_q == C_LAST_PHASE);

`ifdef OSCHED_PRBS_EN
   localparam logic [6:0] C_PRBS_SEED = 7'h7F;
   logic [6:0] lfsr_q, lfsr_d, w_lfsr_adv;

   // x^7+x^6+1, WORD_W steps per word, first generated bit lands in bit 0
   always_comb begin
      w_lfsr_adv   = lfsr_q;
      w_train_word = '0;
      for (int i = 0; i < WORD_W; i++) begin
         w_train_word[i] = w_lfsr_adv[6] ^ w_lfsr_adv[5];
         w_lfsr_adv      = {w_lfsr_adv[5:0], w_train_word[i]};
      end
   end

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_d != S_TRAIN) begin
         lfsr_d = C_PRBS_SEED;
      end else if (en && w_boundary && state_q != S_OFF) begin
         lfsr_d = w_lfsr_adv;
      end
   end

   always_ff @(posedge clk_ser or posedge rst) begin
      if (rst) lfsr_q <= C_PRBS_SEED;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign w_train_word = TRAIN_WORD;
`endif

   always_comb begin
      state_d      = state_q;
      phase_d      = 3'd0;
      ser_word_d   = ser_word_q;
      word_cnt_d   = word_cnt_q;
      starv_d      = bus.b_valid ? starv_q : '0;
      idle_cnt_d   = idle_cnt_q;
      w_a_ready    = 1'b0;
      w_b_ready    = 1'b0;
      w_train_done = 1'b0;
      if (!en) begin
         state_d    = S_OFF;
         ser_word_d = IDLE_WORD;
         word_cnt_d = '0;
      end else begin
         if (state_q != S_OFF && !w_boundary) phase_d = phase_q + 3'd1;
         case (state_q)
            S_OFF: begin
               state_d    = S_TRAIN;
               ser_word_d = IDLE_WORD;
               word_cnt_d = '0;
               starv_d    = '0;
               idle_cnt_d = '0;
            end
            S_TRAIN: begin
               if (w_boundary) begin
                  ser_word_d = w_train_word;
                  if (word_cnt_q == C_LAST_WORD) begin
                     state_d      = S_DATA;
                     word_cnt_d   = '0;
                     w_train_done = 1'b1;
                  end else begin
                     word_cnt_d = word_cnt_q + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_boundary) begin
                  if (train_req) begin
                     // this boundary already carries the first training word
                     ser_word_d = w_train_word;
                     idle_cnt_d = '0;
                     starv_d    = '0;
                     if (TRAIN_LEN == 1) begin
                        w_train_done = 1'b1;
                     end else begin
                        state_d    = S_TRAIN;
                        word_cnt_d = C_FIRST_WORD;
                     end
                  end else if (bus.a_valid && !(bus.b_valid && starv_q == C_STARV_LIM)) begin
                     w_a_ready  = 1'b1;
                     ser_word_d = bus.a_data;
                     if (bus.b_valid) starv_d = starv_q + 1'b1;
                  end else if (bus.b_valid) begin
                     w_b_ready  = 1'b1;
                     ser_word_d = bus.b_data;
                     starv_d    = '0;
                  end else begin
                     ser_word_d = IDLE_WORD;
                     if (idle_cnt_q != 16'hFFFF) idle_cnt_d = idle_cnt_q + 16'd1;
                  end
               end
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_ser or posedge rst) begin
      if (rst) begin
         state_q    <= S_OFF;
         phase_q    <= 3'd0;
         ser_word_q <= IDLE_WORD;
         word_cnt_q <= '0;
         starv_q    <= '0;
         idle_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ser_word_q <= ser_word_d;
         word_cnt_q <= word_cnt_d;
         starv_q    <= starv_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign bus.ser_load = w_boundary && (state_q != S_OFF);
   assign bus.ser_word = ser_word_q;
   assign bus.a_ready  = w_a_ready;
   assign bus.b_ready  = w_b_ready;
   assign phase        = phase_q;
   assign state_o      = state_q;
   assign train_done   = w_train_done;
   assign idle_cnt     = idle_cnt_q;
endmodule
`default_nettype wire
